// File: rtl/byte_divider.sv
`default_nettype none
// ============================================================================
// Module   : byte_divider
// Purpose  : Sequential restoring divider, A / B -> Q, R, one quotient bit per
//            clock, with a start/busy/done handshake and divide-by-zero flag.
// Revision : 1.0  initial release
// ============================================================================
module byte_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             flag
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH:0]   w_rem_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
  assign w_accept  = start && (r_state != S_CALC);
  assign w_b_zero  = (B == '0);
  assign w_last    = (r_cnt == C_LAST);

  // The shifted partial remainder keeps its carry-out bit so the compare is exact;
  // when it is >= divisor the difference always fits back into WIDTH bits.
  assign w_rem_t   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_t >= {1'b0, r_div});
  assign w_rem_sub = w_rem_t[WIDTH-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_t[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next_state = w_b_zero ? S_DONE : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CALC);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      Q     <= '0;
      R     <= '0;
      flag  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= A;
      r_div <= B;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      // Divide-by-zero resolves immediately; otherwise results hold until the new load.
      if (w_b_zero) begin
        Q    <= '1;
        R    <= A;
        flag <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_dvd <= r_dvd << 1;
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        Q    <= w_quo_nxt;
        R    <= w_rem_nxt;
        flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_divider
// Purpose  : Directed and random self-checking bench for byte_divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_byte_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .flag  (flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Continue counting edges from edges_in until done is seen (bounded).
  task automatic wait_done(input int edges_in, input int busy_in, output int edges, output int busy_cnt);
    edges    = edges_in;
    busy_cnt = busy_in;
    forever begin
      if (done) break;
      if (edges >= 40) begin
        check("timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int edges, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, busy ? 1 : 0, edges, busy_cnt);
  endtask

  int       e, bc;
  logic [7:0] ra, rb, eq, er;
  logic       ef;

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flag", flag, 0);
    rst = 1'b0;

    // Basic division and latency
    run_op(8'd200, 8'd7, e, bc);
    check("t1_edges", e, 9);
    check("t1_busy_cycles", bc, 8);
    check("t1_busy_in_done", busy, 0);
    check("t1_Q", Q, 28);
    check("t1_R", R, 4);
    check("t1_flag", flag, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_Q_hold", Q, 28);

    // Edge cases
    run_op(8'd255, 8'd1, e, bc);
    check("t2a_QR", {Q, R}, {8'd255, 8'd0});
    run_op(8'd5, 8'd9, e, bc);
    check("t2b_QR", {Q, R}, {8'd0, 8'd5});
    run_op(8'd0, 8'd3, e, bc);
    check("t2c_QR", {Q, R}, {8'd0, 8'd0});

    // Divide by zero
    run_op(8'd77, 8'd0, e, bc);
    check("t3_edges", e, 1);
    check("t3_busy_never", bc, 0);
    check("t3_flag", flag, 1);
    check("t3_QR", {Q, R}, {8'hFF, 8'd77});
    repeat (3) @(negedge clk);
    check("t3_flag_hold", flag, 1);
    check("t3_done_low", done, 0);

    // Start while busy is ignored, operand changes ignored
    @(negedge clk);
    A = 8'd100; B = 8'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    A = 8'd9; B = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t4_busy_mid", busy, 1);
    wait_done(3, 0, e, bc);
    check("t4_edges", e, 9);
    check("t4_QR", {Q, R}, {8'd10, 8'd0});
    check("t4_flag", flag, 0);

    // Reset mid-division; flag from a divide-by-zero must be cleared too
    run_op(8'd1, 8'd0, e, bc);
    @(negedge clk);
    A = 8'd250; B = 8'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_flag_held_calc", flag, 1);
    check("t5_Q_held_calc", Q, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_QR", {Q, R}, 0);
    check("t5_rst_ctl", {busy, done, flag}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_idle", {busy, done}, 0);
    run_op(8'd250, 8'd6, e, bc);
    check("t5_edges", e, 9);
    check("t5_QR", {Q, R}, {8'd41, 8'd4});

    // Back-to-back: new start accepted in the done cycle
    run_op(8'd60, 8'd7, e, bc);
    check("t6_first_QR", {Q, R}, {8'd8, 8'd4});
    A = 8'd13; B = 8'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t6_accepted_busy", busy, 1);
    check("t6_Q_hold_newop", {Q, R}, {8'd8, 8'd4});
    wait_done(1, 1, e, bc);
    check("t6_edges", e, 9);
    check("t6_QR", {Q, R}, {8'd3, 8'd1});

    // Random operands against the reference operators
    for (int i = 0; i < 1200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (rb == 8'd0) begin
        eq = 8'hFF; er = ra; ef = 1'b1;
      end else begin
        eq = ra / rb; er = ra % rb; ef = 1'b0;
      end
      run_op(ra, rb, e, bc);
      check($sformatf("rand_%0d_%0d", ra, rb), {flag, Q, R}, {ef, eq, er});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
